// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, default
// bus widths and the data-grant starvation limit.
package riscv_pkg;

  localparam int unsigned ARB_ADDR_W   = 32;
  localparam int unsigned ARB_DATA_W   = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single-port memory.
// Optional access timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be within 2..255");
  end

  arb_state_t                r_state;
  logic                      r_mem_req;
  logic                      r_mem_we;
  logic [ADDR_W-1:0]         r_mem_addr;
  logic [DATA_W-1:0]         r_mem_wdata;
  logic [DATA_W/8-1:0]       r_mem_be;
  logic                      r_i_ack;
  logic                      r_d_ack;
  logic [DATA_W-1:0]         r_i_rdata;
  logic [DATA_W-1:0]         r_d_rdata;
  logic [2:0]                r_starve;
  logic                      w_timeout;
  logic                      w_done;
  logic [DATA_W-1:0]         w_rdata;
  logic                      w_fetch_wins;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0]                r_tcnt;
  logic                      r_err;
`endif

  always_comb begin
    w_timeout = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    w_timeout = (r_tcnt == 8'(TIMEOUT - 1));
`endif
    w_done       = mem_ack | w_timeout;
    // A timed-out access returns zero data; a real ack wins if both coincide.
    w_rdata      = mem_ack ? mem_rdata : '0;
    w_fetch_wins = i_req & (~d_req | (r_starve >= 3'(STARVE_LIMIT)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_starve    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_tcnt      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          r_tcnt <= '0;
`endif
          // The ack cycle is a dead cycle: requesters still show req for it.
          if (!(r_i_ack || r_d_ack)) begin
            if (w_fetch_wins) begin
              r_state     <= GRANT_I;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= i_addr;
              r_mem_wdata <= '0;
              r_mem_be    <= '1;
              r_starve    <= '0;
            end else if (d_req) begin
              r_state     <= GRANT_D;
              r_mem_req   <= 1'b1;
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
              r_mem_be    <= d_be;
              r_starve    <= i_req ? r_starve + 3'd1 : '0;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (w_done) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            if (r_state == GRANT_I) begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= w_rdata;
            end else begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= w_rdata;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            r_err <= w_timeout & ~mem_ack;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
`endif
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of per-cycle vectors plus hand-written
// sequences for starvation, reset mid-grant and the timeout / no-timeout builds.
module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ack, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  typedef struct {
    logic        rst, ireq;
    logic [31:0] iaddr;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbe;
    logic        mack;
    logic [31:0] mrdata;
    logic        e_mreq, e_mwe;
    logic [31:0] e_maddr, e_mwdata;
    logic [3:0]  e_mbe;
    logic        e_iack, e_dack;
    logic [31:0] e_irdata, e_drdata;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_ack = 1'b0; mem_rdata = '0;

    //          rst ireq iaddr      dreq dwe daddr      dwdata        dbe    mack mrdata    | mreq mwe maddr      mwdata        mbe    iack dack irdata     drdata
    tv[0]  = '{H, L, Z,         L, L, Z,         Z,            4'h0, L, Z,         L, L, Z,         Z,            4'h0, L, L, Z,         Z};
    tv[1]  = '{L, H, 32'h10,    L, L, Z,         Z,            4'h0, L, Z,         H, L, 32'h10,    Z,            4'hF, L, L, Z,         Z};
    tv[2]  = '{L, H, 32'h10,    L, L, Z,         Z,            4'h0, L, Z,         H, L, 32'h10,    Z,            4'hF, L, L, Z,         Z};
    tv[3]  = '{L, H, 32'h10,    L, L, Z,         Z,            4'h0, H, 32'h13,    L, L, 32'h10,    Z,            4'hF, H, L, 32'h13,    Z};
    tv[4]  = '{L, L, Z,         L, L, Z,         Z,            4'h0, L, Z,         L, L, 32'h10,    Z,            4'hF, L, L, 32'h13,    Z};
    tv[5]  = '{L, H, 32'h20,    H, H, 32'h100,   32'hDEADBEEF, 4'hF, L, Z,         H, H, 32'h100,   32'hDEADBEEF, 4'hF, L, L, 32'h13,    Z};
    tv[6]  = '{L, H, 32'h20,    H, H, 32'h100,   32'hDEADBEEF, 4'hF, H, 32'h55,    L, H, 32'h100,   32'hDEADBEEF, 4'hF, L, H, 32'h13,    32'h55};
    tv[7]  = '{L, H, 32'h20,    L, L, Z,         Z,            4'h0, L, Z,         L, H, 32'h100,   32'hDEADBEEF, 4'hF, L, L, 32'h13,    32'h55};
    tv[8]  = '{L, H, 32'h20,    L, L, Z,         Z,            4'h0, L, Z,         H, L, 32'h20,    Z,            4'hF, L, L, 32'h13,    32'h55};
    tv[9]  = '{L, H, 32'h20,    L, L, Z,         Z,            4'h0, H, 32'h77,    L, L, 32'h20,    Z,            4'hF, H, L, 32'h77,    32'h55};
    tv[10] = '{L, L, Z,         L, L, Z,         Z,            4'h0, L, Z,         L, L, 32'h20,    Z,            4'hF, L, L, 32'h77,    32'h55};

    for (int i = 0; i < 11; i++) begin
      reset = tv[i].rst; i_req = tv[i].ireq; i_addr = tv[i].iaddr;
      d_req = tv[i].dreq; d_we = tv[i].dwe; d_addr = tv[i].daddr;
      d_wdata = tv[i].dwdata; d_be = tv[i].dbe;
      mem_ack = tv[i].mack; mem_rdata = tv[i].mrdata;
      step();
      chk($sformatf("v%0d mem_req", i),   32'(mem_req),   32'(tv[i].e_mreq));
      chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(tv[i].e_mwe));
      chk($sformatf("v%0d mem_addr", i),  mem_addr,       tv[i].e_maddr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata,      tv[i].e_mwdata);
      chk($sformatf("v%0d mem_be", i),    32'(mem_be),    32'(tv[i].e_mbe));
      chk($sformatf("v%0d i_ack", i),     32'(i_ack),     32'(tv[i].e_iack));
      chk($sformatf("v%0d d_ack", i),     32'(d_ack),     32'(tv[i].e_dack));
      chk($sformatf("v%0d i_rdata", i),   i_rdata,        tv[i].e_irdata);
      chk($sformatf("v%0d d_rdata", i),   d_rdata,        tv[i].e_drdata);
      chk($sformatf("v%0d err", i),       32'(err),       32'(1'b0));
    end

    // Starvation: d_req held through five loads with a fetch pending.
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
    for (int k = 0; k < 5; k++) begin
      d_addr = 32'h200 + 32'(4 * k);
      mem_ack = 1'b0;
      step();
      chk($sformatf("starve%0d mem_req", k), 32'(mem_req), 32'(1'b1));
      chk($sformatf("starve%0d mem_addr", k), mem_addr, (k < 4) ? d_addr : 32'h40);
      mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(k);
      step();
      chk($sformatf("starve%0d i_ack", k), 32'(i_ack), (k < 4) ? 32'h0 : 32'h1);
      chk($sformatf("starve%0d d_ack", k), 32'(d_ack), (k < 4) ? 32'h1 : 32'h0);
      mem_ack = 1'b0;
      step();
      chk($sformatf("starve%0d turnaround", k), 32'(mem_req), 32'(1'b0));
    end
    chk("starve fetch rdata", i_rdata, 32'h1004);
    step();
    chk("post-starve data grant", mem_addr, 32'h210);
    chk("post-starve mem_we", 32'(mem_we), 32'(1'b0));
    mem_ack = 1'b1; mem_rdata = 32'h2222;
    step();
    chk("post-starve d_rdata", d_rdata, 32'h2222);
    i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    step();

    // Reset in the middle of a store grant.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h12345678; d_be = 4'h3;
    step();
    chk("rst-mid grant mem_req", 32'(mem_req), 32'(1'b1));
    chk("rst-mid grant mem_be", 32'(mem_be), 32'h3);
    reset = 1'b1;
    step();
    chk("rst-mid mem_req", 32'(mem_req), 32'(1'b0));
    chk("rst-mid d_ack", 32'(d_ack), 32'(1'b0));
    chk("rst-mid err", 32'(err), 32'(1'b0));
    chk("rst-mid mem_be", 32'(mem_be), 32'h0);
    chk("rst-mid state idle", 32'(dut.r_state == IDLE), 32'(1'b1));
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h44;
    step();
    chk("rst-held no grant", 32'(mem_req), 32'(1'b0));
    reset = 1'b0;
    step();
    chk("rst-release grant", 32'(mem_req), 32'(1'b1));
    chk("rst-release addr", mem_addr, 32'h44);
    chk("rst-release d_ack", 32'(d_ack), 32'(1'b0));
    mem_ack = 1'b1; mem_rdata = 32'h99;
    step();
    chk("rst-release i_rdata", i_rdata, 32'h99);
    i_req = 1'b0; mem_ack = 1'b0;
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    i_req = 1'b1; i_addr = 32'h80;
    step();
    chk("to G1 mem_req", 32'(mem_req), 32'(1'b1));
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("to G%0d mem_req", c), 32'(mem_req), 32'(1'b1));
      chk($sformatf("to G%0d err", c), 32'(err), 32'(1'b0));
    end
    step();
    chk("to mem_req drop", 32'(mem_req), 32'(1'b0));
    chk("to i_ack", 32'(i_ack), 32'(1'b1));
    chk("to err", 32'(err), 32'(1'b1));
    chk("to i_rdata", i_rdata, 32'h0);
    i_req = 1'b0;
    step();
    chk("to i_ack pulse", 32'(i_ack), 32'(1'b0));
    chk("to err pulse", 32'(err), 32'(1'b0));
`else
    i_req = 1'b1; i_addr = 32'h84;
    step();
    chk("wait grant", 32'(mem_req), 32'(1'b1));
    i_req = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      chk($sformatf("wait%0d mem_req", c), 32'(mem_req), 32'(1'b1));
      chk($sformatf("wait%0d err", c), 32'(err), 32'(1'b0));
      chk($sformatf("wait%0d i_ack", c), 32'(i_ack), 32'(1'b0));
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    step();
    chk("wait i_ack", 32'(i_ack), 32'(1'b1));
    chk("wait i_rdata", i_rdata, 32'hCAFE);
    mem_ack = 1'b0;
    step();
    chk("wait i_ack pulse", 32'(i_ack), 32'(1'b0));
    chk("wait i_rdata hold", i_rdata, 32'hCAFE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; DATA_W/8 byte enables.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles waiting for mem_ack (range 2..255).
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports i_req in 1, i_addr in ADDR_W, i_ack out 1, i_rdata out DATA_W  instruction-fetch requester (PC side).
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_be in DATA_W/8, d_ack out 1, d_rdata out DATA_W  load/store requester.
REQ-008 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_be out DATA_W/8, mem_ack in 1, mem_rdata in DATA_W  single-port memory.
REQ-009 SHALL have port err out 1  one-cycle pulse on a timed-out access.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-011 In IDLE, d_req high SHALL move to GRANT_D next cycle; else i_req high SHALL move to GRANT_I; else stay IDLE.
REQ-012 With i_req and d_req both high in IDLE, data SHALL win (fixed priority) unless REQ-030 applies.
REQ-013 On grant entry, the arbiter SHALL latch the winner's address/we/wdata/be into registers and drive mem_* from them; mem_req high for the whole grant.
REQ-014 Requesters SHALL hold req and inputs stable until ack; arbiter samples only at grant entry.
REQ-015 On mem_ack in GRANT_x, the arbiter SHALL pulse x_ack for exactly one cycle with x_rdata = registered mem_rdata, deassert mem_req, and return to IDLE (ack latency = mem_ack cycle + 1).
REQ-016 Minimum turnaround: no new grant in the cycle x_ack is high; next grant earliest the following cycle.
REQ-017 The non-granted requester's ack SHALL stay low; its request waits in place.
REQ-018 mem_we SHALL be 0 for fetches; mem_be SHALL be all-ones for fetches.
REQ-019 i_rdata/d_rdata SHALL hold their last value between acks.
REQ-020 A requester dropping req mid-grant SHALL not abort the memory access; the ack is still issued.

Reset
REQ-021 While reset is high at a clock edge, state SHALL become IDLE; mem_req, mem_we, i_ack, d_ack, err SHALL be 0; mem_addr, mem_wdata, i_rdata, d_rdata 0; mem_be 0.
REQ-022 Reset mid-grant SHALL abandon the access with no ack and no err pulse.
REQ-023 First grant after reset release SHALL occur no earlier than the first edge with reset low.

Configuration
REQ-024 Macro MEM_ARB_TIMEOUT_EN defined: a cycle counter SHALL run during each grant; reaching TIMEOUT without mem_ack SHALL deassert mem_req, pulse x_ack with x_rdata = 0, pulse err, and return to IDLE.
REQ-025 Macro MEM_ARB_TIMEOUT_EN undefined: no counter; grants wait indefinitely; err SHALL be tied 0.
REQ-030 Starvation guard (always present): after 4 consecutive data grants with i_req pending, the next IDLE arbitration SHALL grant fetch; counter clears on any fetch grant.

Structure
REQ-026 Shared package riscv_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W defaults and the starvation limit constant (4).
REQ-027 Implementation SHALL be a single module; no sub-module.

Verification
REQ-028 Bench SHALL cover:
- i_req only, addr 0x0000_0010, mem_ack 2 cycles later with 0x0000_0013 -> i_ack one cycle after mem_ack, i_rdata 0x0000_0013, d_ack 0.
- i_req and d_req (store 0x100, data 0xDEAD_BEEF, be 0xF) same cycle -> GRANT_D first, mem_we 1; fetch granted after d_ack.
- d_req held high for 5 back-to-back loads with i_req pending -> 5th arbitration grants fetch.
- Reset asserted during GRANT_D before mem_ack -> mem_req 0 next cycle, no d_ack, no err, state IDLE.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=4, mem_ack never asserted -> after 4 grant cycles err and i_ack pulse once, i_rdata 0.
- Without MEM_ARB_TIMEOUT_EN, mem_ack withheld 50 cycles -> mem_req stays high, err 0, ack on eventual mem_ack.
